// File: rtl/rvx_gpio_pkg.sv
// -----------------------------------------------------------------------------
// rvx_gpio_pkg
//   Shared constants for the GPIO pad front end.
//   - DEFAULT_SYNC_STAGES     : synchroniser depth used when a parent does not
//                               override it.
//   - DEFAULT_DEBOUNCE_CYCLES : 10 ms at the 12 MHz board clock.
//   - cycles_from_us()        : converts a time in microseconds into clock
//                               cycles for a given clock frequency (Hz), so
//                               board tops can derive debounce lengths from
//                               their own clock.
// -----------------------------------------------------------------------------
package rvx_gpio_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 12_000_000;
  localparam int DEFAULT_DEBOUNCE_US     = 10_000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // 64-bit intermediate so that e.g. 100 MHz * 1 s does not overflow.
  function automatic int cycles_from_us(input int clock_frequency, input int us);
    longint prod;
    prod = longint'(clock_frequency) * longint'(us);
    return int'(prod / 64'sd1_000_000);
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES =
    cycles_from_us(DEFAULT_CLOCK_FREQUENCY, DEFAULT_DEBOUNCE_US);

endpackage

// File: rtl/gpio_pin_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_pin_conditioner
//   Conditioning for a single GPIO pin: synchroniser chain, optional counter
//   debounce, output-mode loopback and one-cycle edge events.
//
// Ports
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   warm             in   1 while the shared post-reset warm-up is running
//   pad              in   raw pad level (always sampled, whatever the mode)
//   oe               in   1 = pin is driven by us (output mode)
//   drive_value      in   level driven onto the pad when oe = 1
//   debounce_enable  in   1 = debounce in input mode; 0 = synchroniser only
//   level            out  conditioned pin level (the 'stable' register)
//   rise             out  1-cycle pulse when level goes 0 -> 1
//   fall             out  1-cycle pulse when level goes 1 -> 0
// -----------------------------------------------------------------------------
module gpio_pin_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic warm,
  input  logic pad,
  input  logic oe,
  input  logic drive_value,
  input  logic debounce_enable,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable;
  logic                   stable_n;
  logic                   stable_d;
  logic                   stable_d_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic                   debounce_enable_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Next-state rules, highest priority first.
  always_comb begin
    stable_n   = stable;
    stable_d_n = stable;
    cnt_n      = '0;
    if (warm) begin
      // Load the real pin level without debounce. stable_d follows the new
      // value too, so the warm-up load never looks like an edge and a pin
      // held high through reset produces no rise event.
      stable_n   = oe ? drive_value : sync_out;
      stable_d_n = stable_n;
    end else if (oe) begin
      stable_n = drive_value;
    end else if (debounce_enable != debounce_enable_q) begin
      // Mode change seen on this edge: only clear the count; the new rule
      // takes over from the next edge.
      stable_n = stable;
    end else if (!debounce_enable) begin
      stable_n = sync_out;
    end else if (sync_out != stable) begin
      if (cnt == CNT_LAST) begin
        stable_n = sync_out;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q            <= '0;
      stable            <= 1'b0;
      stable_d          <= 1'b0;
      cnt               <= '0;
      debounce_enable_q <= 1'b0;
    end else begin
      sync_q            <= {sync_q[SYNC_STAGES-2:0], pad};
      stable            <= stable_n;
      stable_d          <= stable_d_n;
      cnt               <= cnt_n;
      debounce_enable_q <= debounce_enable;
    end
  end

  assign level = stable;
  // Both terms come straight from flops, so the pulses are glitch-free and
  // line up with the cycle in which 'level' changes.
  assign rise  = stable & ~stable_d;
  assign fall  = ~stable & stable_d;

endmodule

// File: rtl/gpio_pad_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_pad_conditioner
//   Per-pin GPIO pad front end between the board inout pins and the rvx GPIO
//   port. Drives each pad tristate, and conditions each pin through its own
//   gpio_pin_conditioner. Holds the warm-up counter shared by all pins.
//
// Ports
//   clock            in     system clock
//   reset            in     synchronous, active-high reset
//   gpio             inout  board pads
//   gpio_oe          in     1 = pin driven (output mode)
//   gpio_output      in     value driven when gpio_oe = 1
//   debounce_enable  in     1 = debounce pin in input mode; 0 = synchroniser only
//   gpio_input       out    conditioned pin level, to rvx gpio_input
//   rise_event       out    1-cycle pulse on gpio_input 0 -> 1
//   fall_event       out    1-cycle pulse on gpio_input 1 -> 0
// -----------------------------------------------------------------------------
module gpio_pad_conditioner
  import rvx_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH      = 3,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire  [GPIO_WIDTH-1:0] gpio,
  input  logic [GPIO_WIDTH-1:0] gpio_oe,
  input  logic [GPIO_WIDTH-1:0] gpio_output,
  input  logic [GPIO_WIDTH-1:0] debounce_enable,
  output logic [GPIO_WIDTH-1:0] gpio_input,
  output logic [GPIO_WIDTH-1:0] rise_event,
  output logic [GPIO_WIDTH-1:0] fall_event
);

  // Warm-up spans the synchroniser fill plus the first load of 'stable'.
  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_CYCLES);

  logic [WARM_W-1:0] warm_cnt;
  logic              warm;

  always_ff @(posedge clock) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_DONE) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  assign warm = (warm_cnt != WARM_DONE);

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    assign gpio[i] = gpio_oe[i] ? gpio_output[i] : 1'bz;

    gpio_pin_conditioner #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pin (
      .clock           (clock),
      .reset           (reset),
      .warm            (warm),
      .pad             (gpio[i]),
      .oe              (gpio_oe[i]),
      .drive_value     (gpio_output[i]),
      .debounce_enable (debounce_enable[i]),
      .level           (gpio_input[i]),
      .rise            (rise_event[i]),
      .fall            (fall_event[i])
    );
  end

endmodule

// File: tb/tb_gpio_pad_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_pad_conditioner
//   Directed bench for gpio_pad_conditioner (3 pins, 2 sync stages, debounce
//   of 4 cycles). Each step drives the pads/controls right after a rising
//   edge, pushes the expected {gpio_input, rise_event, fall_event} for the
//   following edges onto exp_q, then samples 1 time unit after each edge and
//   pops/compares. ext_val models the board: it drives a pin only while the
//   DUT is not driving it (ext_val[0] = 1 acts as a pull-up on pin 0).
// -----------------------------------------------------------------------------
module tb_gpio_pad_conditioner;

  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [W-1:0] gpio_oe;
  logic [W-1:0] gpio_output;
  logic [W-1:0] debounce_enable;
  logic [W-1:0] ext_val;
  wire  [W-1:0] gpio;
  logic [W-1:0] gpio_input;
  logic [W-1:0] rise_event;
  logic [W-1:0] fall_event;

  for (genvar i = 0; i < W; i++) begin : g_board
    assign gpio[i] = gpio_oe[i] ? 1'bz : ext_val[i];
  end

  gpio_pad_conditioner #(
    .GPIO_WIDTH      (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .gpio            (gpio),
    .gpio_oe         (gpio_oe),
    .gpio_output     (gpio_output),
    .debounce_enable (debounce_enable),
    .gpio_input      (gpio_input),
    .rise_event      (rise_event),
    .fall_event      (fall_event)
  );

  // ---------------- scoreboard ----------------
  logic [3*W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [3*W-1:0] ob(input logic [W-1:0] in_v,
                                       input logic [W-1:0] r_v,
                                       input logic [W-1:0] f_v);
    return {in_v, r_v, f_v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push(input int n, input logic [3*W-1:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic run(input int n, input string tag);
    logic [3*W-1:0] exp_v;
    logic [3*W-1:0] got_v;
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {gpio_input, rise_event, fall_event};
      n_cmp++;
      assert (got_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s step %0d (cycle %0d): in/rise/fall observed %b/%b/%b expected %b/%b/%b",
               tag, i, cyc, got_v[8:6], got_v[5:3], got_v[2:0],
               exp_v[8:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset           = 1'b1;
    gpio_oe         = 3'b000;
    gpio_output     = 3'b000;
    debounce_enable = 3'b101;
    ext_val         = 3'b001;

    // Reset with pin 0 pulled high; no rise may appear during warm-up.
    push(3, ob(3'b000, 3'b000, 3'b000));
    run(3, "reset_hold");
    reset = 1'b0;
    push(2, ob(3'b000, 3'b000, 3'b000));
    push(4, ob(3'b001, 3'b000, 3'b000));
    run(6, "warmup");

    // Pin 1, synchroniser only: level and rise at N+3.
    ext_val[1] = 1'b1;
    push(2, ob(3'b001, 3'b000, 3'b000));
    push(1, ob(3'b011, 3'b010, 3'b000));
    push(2, ob(3'b011, 3'b000, 3'b000));
    run(5, "bypass_rise");

    // Pin 2 debounced: 3-cycle pulse is rejected.
    ext_val[2] = 1'b1;
    push(3, ob(3'b011, 3'b000, 3'b000));
    run(3, "glitch_hi");
    ext_val[2] = 1'b0;
    push(6, ob(3'b011, 3'b000, 3'b000));
    run(6, "glitch_lo");

    // Pin 2: count reaches 3, then debounce is switched off. Count clears on
    // that edge; bypass accepts one edge later.
    ext_val[2] = 1'b1;
    push(5, ob(3'b011, 3'b000, 3'b000));
    run(5, "deb_pending");
    debounce_enable[2] = 1'b0;
    push(1, ob(3'b011, 3'b000, 3'b000));
    push(1, ob(3'b111, 3'b100, 3'b000));
    push(2, ob(3'b111, 3'b000, 3'b000));
    run(4, "deb_switch");

    // Pin 2 debounced again: clean fall after SYNC_STAGES + DEBOUNCE edges.
    debounce_enable[2] = 1'b1;
    ext_val[2] = 1'b0;
    push(5, ob(3'b111, 3'b000, 3'b000));
    push(1, ob(3'b011, 3'b000, 3'b100));
    push(1, ob(3'b011, 3'b000, 3'b000));
    run(7, "deb_fall");

    // Pin 2 held high: clean debounced rise at N+6.
    ext_val[2] = 1'b1;
    push(5, ob(3'b011, 3'b000, 3'b000));
    push(1, ob(3'b111, 3'b100, 3'b000));
    push(2, ob(3'b111, 3'b000, 3'b000));
    run(8, "deb_rise");

    // Pin 0 output mode: same level first (no event), then drive low.
    gpio_output[0] = 1'b1;
    gpio_oe[0]     = 1'b1;
    push(2, ob(3'b111, 3'b000, 3'b000));
    run(2, "oe_on");
    gpio_output[0] = 1'b0;
    push(1, ob(3'b110, 3'b000, 3'b001));
    push(1, ob(3'b110, 3'b000, 3'b000));
    run(2, "oe_fall");
    n_cmp++;
    assert (gpio[0] === 1'b0) else begin
      n_fail++;
      $error("FAIL pad_drive: pad0 observed %b expected 0", gpio[0]);
    end

    // Release pin 0 with the pull-up: debounced rise after 6 edges.
    gpio_oe[0] = 1'b0;
    push(5, ob(3'b110, 3'b000, 3'b000));
    push(1, ob(3'b111, 3'b001, 3'b000));
    push(1, ob(3'b111, 3'b000, 3'b000));
    run(7, "oe_release");

    // Pins 1 and 2 debounced, both change on the same edge.
    debounce_enable = 3'b111;
    ext_val[2:1]    = 2'b00;
    push(5, ob(3'b111, 3'b000, 3'b000));
    push(1, ob(3'b001, 3'b000, 3'b110));
    push(1, ob(3'b001, 3'b000, 3'b000));
    run(7, "dual_fall");
    ext_val[2:1] = 2'b11;
    push(5, ob(3'b001, 3'b000, 3'b000));
    push(1, ob(3'b111, 3'b110, 3'b000));
    push(1, ob(3'b111, 3'b000, 3'b000));
    run(7, "dual_rise");

    // Reset while both counters sit at 2, then warm-up again.
    ext_val[2:1] = 2'b00;
    push(4, ob(3'b111, 3'b000, 3'b000));
    run(4, "pre_reset");
    reset = 1'b1;
    push(2, ob(3'b000, 3'b000, 3'b000));
    run(2, "reset_mid");
    reset = 1'b0;
    push(2, ob(3'b000, 3'b000, 3'b000));
    push(3, ob(3'b001, 3'b000, 3'b000));
    run(5, "rewarm");

    // Fresh counters after reset: debounced rise on pin 1 lands at N+6.
    ext_val[1] = 1'b1;
    push(5, ob(3'b001, 3'b000, 3'b000));
    push(1, ob(3'b011, 3'b010, 3'b000));
    push(1, ob(3'b011, 3'b000, 3'b000));
    run(7, "post_reset_rise");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
